// File: rtl/pmem_line_responder.sv
// Line-granular physical memory that terminates the cache's 256-bit pmem port.
// Each request is answered after a fixed LATENCY with a one-cycle pmem_resp pulse; traffic counters run alongside.
module pmem_line_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [255:0] pmem_rdata,
  input  logic         if_miss,
  output logic         busy,
  output logic [31:0]  read_count,
  output logic [31:0]  write_count,
  output logic [31:0]  miss_count,
  output logic         proto_err
);

  localparam int         IDXW      = $clog2(DEPTH);
  localparam logic [7:0] LAT_M1    = 8'(LATENCY - 1);
  localparam bit         SKIP_WAIT = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    RECOVER
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cntNext;
  logic              w_accept;
  logic              w_reqAny;
  logic              w_rdOp;
  logic [IDXW-1:0]   w_rdIndex;
  logic [IDXW-1:0]   w_addrIndex;

  logic              r_isWrite;
  logic [IDXW-1:0]   r_index;
  logic [255:0]      r_wdata;

  logic              r_resp;
  logic              r_busy;
  logic [255:0]      r_rdata;
  logic [31:0]       r_readCount;
  logic [31:0]       r_writeCount;
  logic [31:0]       r_missCount;
  logic              r_protoErr;

  logic [255:0]      r_mem [DEPTH];

  logic [31:0]       w_unused;

  assign w_addrIndex = pmem_address[5 +: IDXW];
  assign w_reqAny    = pmem_read | pmem_write;
  assign w_unused    = {pmem_address[31:5+IDXW], pmem_address[4:0], {(IDXW){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cntNext;
    end
  end

  // With LATENCY of 1 the request goes straight to RESP, skipping WAIT.
  always_comb begin
    w_next    = r_state;
    w_cntNext = r_cnt;
    w_accept  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_reqAny) begin
          w_accept  = 1'b1;
          w_cntNext = LAT_M1;
          w_next    = SKIP_WAIT ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt <= 8'd1) begin
          w_next = RESP;
        end else begin
          w_cntNext = r_cnt - 8'd1;
        end
      end
      RESP:    w_next = RECOVER;
      RECOVER: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // A simultaneous read+write is latched as a write.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_isWrite <= pmem_write;
      r_index   <= w_addrIndex;
      r_wdata   <= pmem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == RESP) && r_isWrite) begin
      r_mem[r_index] <= r_wdata;
    end
  end

  // When entering RESP straight from IDLE the live request decides the read.
  assign w_rdOp    = (r_state == IDLE) ? (pmem_read & ~pmem_write) : ~r_isWrite;
  assign w_rdIndex = (r_state == IDLE) ? w_addrIndex : r_index;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp  <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_resp <= (w_next == RESP);
      r_busy <= (w_next != IDLE);
      if ((w_next == RESP) && (r_state != RESP) && w_rdOp) begin
        r_rdata <= r_mem[w_rdIndex];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_readCount  <= 32'd0;
      r_writeCount <= 32'd0;
      r_protoErr   <= 1'b0;
    end else begin
      if (r_state == RESP) begin
        if (r_isWrite) begin
          r_writeCount <= r_writeCount + 32'd1;
        end else begin
          r_readCount <= r_readCount + 32'd1;
        end
      end
      if (w_accept && pmem_read && pmem_write) begin
        r_protoErr <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_missCount <= 32'd0;
    end else if (if_miss) begin
      r_missCount <= r_missCount + 32'd1;
    end
  end

  assign pmem_resp   = r_resp;
  assign pmem_rdata  = r_rdata;
  assign busy        = r_busy;
  assign read_count  = r_readCount;
  assign write_count = r_writeCount;
  assign miss_count  = r_missCount;
  assign proto_err   = r_protoErr;

endmodule
